// File: rtl/sopc_2_timer_tick_scheduler.sv
// ---------------------------------------------------------------------------
// sopc_2_timer_tick_scheduler
//
// Avalon-MM master that owns the interval timer s1 port. After reset it
// programs the timer period (per_l, per_h) and enables the timeout interrupt.
// It then services every timeout by writing the status register. Each
// serviced timeout advances NUM_CH divider channels. A channel emits a
// one-cycle tick pulse when its count wraps.
//
// Optional feature: define TICK_SCHED_SNAPSHOT_EN to enable counter
// snapshots. A snapshot latches the timer counter with a write to addr 4,
// then reads back snap_l (addr 4) and snap_h (addr 5).
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   tmr_address         timer s1 address (0 status,1 ctrl,2 per_l,3 per_h,4/5 snap)
//   tmr_chipselect      timer s1 chipselect
//   tmr_write_n         timer s1 write strobe, active-low
//   tmr_writedata       timer s1 write data
//   tmr_readdata        timer s1 read data, valid one cycle after the address
//   tmr_irq             timer interrupt, level, held until status is written
//   cfg_wr/cfg_ch/cfg_div  load divide ratio for one channel (0 disables it)
//   init_done           timer programmed, scheduler running
//   tick_out            per-channel one-cycle tick pulses
//   snap_req            snapshot request (snapshot build only)
//   snap_valid          one-cycle pulse when snap_value is updated
//   snap_value          captured timer counter
//   dbg_state           current FSM state, for observation
//
// Bus protocol: a write lasts one cycle, with chipselect=1, write_n=0, and
// address and data valid. A read is a cycle with the address valid and
// chipselect=0; the data is taken from tmr_readdata in the following cycle.
// There is no wait-request; the slave accepts every access.
// ---------------------------------------------------------------------------
module sopc_2_timer_tick_scheduler #(
  parameter logic [31:0] PERIOD = 32'd49999,
  parameter int          NUM_CH = 4,
  parameter int          DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              init_done,
  output logic [NUM_CH-1:0] tick_out,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [3:0]        dbg_state
);

`ifdef TICK_SCHED_SNAPSHOT_EN
  typedef enum logic [3:0] {
    S_INIT_PL = 4'd0, S_INIT_PH = 4'd1, S_INIT_CT = 4'd2, S_IDLE = 4'd3,
    S_CLR = 4'd4, S_WAIT = 4'd5, S_SNAP_WR = 4'd6, S_SNAP_A4 = 4'd7,
    S_SNAP_A5 = 4'd8, S_SNAP_CAP = 4'd9
  } state_t;
  logic r_snap_pend;
`else
  typedef enum logic [3:0] {
    S_INIT_PL = 4'd0, S_INIT_PH = 4'd1, S_INIT_CT = 4'd2, S_IDLE = 4'd3,
    S_CLR = 4'd4, S_WAIT = 4'd5
  } state_t;
`endif

  state_t r_state, w_next;
  // The first clock after reset only loads the INIT_PL write into the bus
  // registers. The FSM therefore holds INIT_PL for that edge. This makes each
  // state's bus access visible in the same cycle the state is current.
  logic r_run;
  logic r_cs;
  logic [2:0] r_address;
  logic [15:0] r_writedata;
  logic r_init_done;
  logic w_cs;
  logic [2:0] w_addr;
  logic [15:0] w_wdata;

  always_comb begin
    w_next = r_state;
    if (r_run) begin
      case (r_state)
        S_INIT_PL: w_next = S_INIT_PH;
        S_INIT_PH: w_next = S_INIT_CT;
        S_INIT_CT: w_next = S_IDLE;
        S_IDLE: begin
          if (tmr_irq) w_next = S_CLR;
`ifdef TICK_SCHED_SNAPSHOT_EN
          else if (r_snap_pend) w_next = S_SNAP_WR;
`endif
        end
        S_CLR:      w_next = S_WAIT;
        S_WAIT:     w_next = S_IDLE;
`ifdef TICK_SCHED_SNAPSHOT_EN
        S_SNAP_WR:  w_next = S_SNAP_A4;
        S_SNAP_A4:  w_next = S_SNAP_A5;
        S_SNAP_A5:  w_next = S_SNAP_CAP;
        S_SNAP_CAP: w_next = S_IDLE;
`endif
        default:    w_next = S_INIT_PL;
      endcase
    end
  end

  // Bus access of the state being entered. It is registered so that the
  // outputs are glitch-free and line up with the state.
  always_comb begin
    w_cs    = 1'b0;
    w_addr  = r_address;
    w_wdata = r_writedata;
    case (w_next)
      S_INIT_PL: begin w_cs = 1'b1; w_addr = 3'd2; w_wdata = PERIOD[15:0];  end
      S_INIT_PH: begin w_cs = 1'b1; w_addr = 3'd3; w_wdata = PERIOD[31:16]; end
      S_INIT_CT: begin w_cs = 1'b1; w_addr = 3'd1; w_wdata = 16'h0001;      end
      S_CLR:     begin w_cs = 1'b1; w_addr = 3'd0; w_wdata = 16'h0000;      end
`ifdef TICK_SCHED_SNAPSHOT_EN
      S_SNAP_WR: begin w_cs = 1'b1; w_addr = 3'd4; w_wdata = 16'h0000;      end
      S_SNAP_A4: w_addr = 3'd4;
      S_SNAP_A5: w_addr = 3'd5;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT_PL;
      r_run       <= 1'b0;
      r_cs        <= 1'b0;
      r_address   <= 3'd0;
      r_writedata <= 16'h0000;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_run       <= 1'b1;
      r_cs        <= w_cs;
      r_address   <= w_addr;
      r_writedata <= w_wdata;
      if (r_state == S_INIT_CT) r_init_done <= 1'b1;
    end
  end

  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = ~r_cs;
  assign tmr_address    = r_address;
  assign tmr_writedata  = r_writedata;
  assign init_done      = r_init_done;
  assign dbg_state      = r_state;

  // Channel dividers. The update is taken on the edge that leaves CLR, so
  // the ticks are visible during WAIT. A cfg write to the same channel on
  // that edge takes priority and suppresses the tick.
  logic [DIV_W-1:0]  r_div [NUM_CH];
  logic [DIV_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_tick;
  logic              w_upd;

  assign w_upd = (r_state == S_CLR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_tick <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_wr && (cfg_ch == 3'(i))) begin
          r_div[i] <= cfg_div;
          r_cnt[i] <= '0;
        end else if (w_upd && (r_div[i] != '0)) begin
          if (r_cnt[i] == r_div[i] - DIV_W'(1)) begin
            r_cnt[i]  <= '0;
            r_tick[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + DIV_W'(1);
          end
        end
      end
    end
  end

  assign tick_out = r_tick;

`ifdef TICK_SCHED_SNAPSHOT_EN
  logic [15:0] r_snap_lo;
  logic        r_snap_valid;
  logic [31:0] r_snap_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_pend  <= 1'b0;
      r_snap_lo    <= 16'h0000;
      r_snap_valid <= 1'b0;
      r_snap_value <= 32'h0;
    end else begin
      r_snap_valid <= 1'b0;
      // Requests that arrive while a snapshot is pending merge into it.
      if (r_state == S_SNAP_CAP) r_snap_pend <= 1'b0;
      else if (snap_req)         r_snap_pend <= 1'b1;
      // During A5, readdata carries the addr-4 read that was issued in A4.
      if (r_state == S_SNAP_A5) r_snap_lo <= tmr_readdata;
      if (r_state == S_SNAP_CAP) begin
        r_snap_value <= {tmr_readdata, r_snap_lo};
        r_snap_valid <= 1'b1;
      end
    end
  end

  assign snap_valid = r_snap_valid;
  assign snap_value = r_snap_value;
`else
  logic w_unused;
  assign w_unused   = ^{snap_req, tmr_readdata};
  assign snap_valid = 1'b0;
  assign snap_value = 32'h0;
`endif

endmodule

// File: tb/tb_sopc_2_timer_tick_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for sopc_2_timer_tick_scheduler.
// Contains a small timer-slave model: it raises irq on request, drops it on a
// status write, and answers snapshot reads. It also contains a behavioural
// expectation model: scheduled bus writes, tick masks per cycle, and snapshot
// results. All of these are derived from the timeout arithmetic. A compare
// process checks every cycle, and literal checks pin the init writes and the
// tick counts.
// ---------------------------------------------------------------------------
module tb_sopc_2_timer_tick_scheduler;
  localparam logic [31:0] PERIOD = 32'd49999;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;

  // clock / reset
  logic clk;
  logic reset_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT connections
  logic [2:0]        tmr_address;
  logic              tmr_chipselect, tmr_write_n;
  logic [15:0]       tmr_writedata, tmr_readdata;
  logic              tmr_irq;
  logic              cfg_wr;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              init_done;
  logic [NUM_CH-1:0] tick_out;
  logic              snap_req, snap_valid;
  logic [31:0]       snap_value;
  logic [3:0]        dbg_state;

  sopc_2_timer_tick_scheduler #(.PERIOD(PERIOD), .NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .init_done(init_done), .tick_out(tick_out),
    .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value),
    .dbg_state(dbg_state)
  );

  // timer slave model
  logic        fire_req;
  logic [31:0] tmr_counter;
  logic [15:0] snap_l, snap_h;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_irq <= 1'b0; tmr_readdata <= 16'h0; snap_l <= 16'h0; snap_h <= 16'h0;
    end else begin
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) tmr_irq <= 1'b0;
      else if (fire_req) tmr_irq <= 1'b1;
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) begin
        snap_l <= tmr_counter[15:0];
        snap_h <= tmr_counter[31:16];
      end
      case (tmr_address)
        3'd4:    tmr_readdata <= snap_l;
        3'd5:    tmr_readdata <= snap_h;
        default: tmr_readdata <= 16'h0;
      endcase
    end
  end

  // scoreboard state
  typedef struct { int cyc; logic [2:0] addr; logic [15:0] data; } wr_t;
  wr_t               wq[$];
  logic [18:0]       wr_log[$];
  logic [NUM_CH-1:0] exp_tick [int];
  logic [31:0]       exp_snap [int];
  int                m_div [NUM_CH];
  int                m_n   [NUM_CH];
  int                tick_cnt [NUM_CH];
  int                init_cyc;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    logic [NUM_CH-1:0] et;
    #1;
    if (!reset_n) begin
      check("reset_bus", {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
      check("reset_tick", 32'(tick_out), 32'h0);
      check("reset_init_done", 32'(init_done), 32'h0);
      check("reset_snap_valid", 32'(snap_valid), 32'h0);
      check("reset_snap_value", snap_value, 32'h0);
    end else begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL write_missing cycle %0d: no write seen, expected addr %0d data %h at cycle %0d",
                 cyc, wq[0].addr, wq[0].data, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        check("bus_write", {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {11'd0, 1'b1, 1'b0, wq[0].addr, wq[0].data});
        void'(wq.pop_front());
      end else begin
        check("bus_idle", {30'd0, tmr_chipselect, tmr_write_n}, 32'h1);
      end
      if (tmr_chipselect) wr_log.push_back({tmr_address, tmr_writedata});
      et = exp_tick.exists(cyc) ? exp_tick[cyc] : '0;
      check("tick_out", 32'(tick_out), 32'(et));
      for (int i = 0; i < NUM_CH; i++) if (tick_out[i]) tick_cnt[i]++;
      check("init_done", 32'(init_done), 32'(cyc >= init_cyc));
`ifdef TICK_SCHED_SNAPSHOT_EN
      if (exp_snap.exists(cyc)) begin
        check("snap_valid", 32'(snap_valid), 32'h1);
        check("snap_value", snap_value, exp_snap[cyc]);
      end else begin
        check("snap_valid_idle", 32'(snap_valid), 32'h0);
      end
`else
      check("snap_valid_off", 32'(snap_valid), 32'h0);
      check("snap_value_off", snap_value, 32'h0);
`endif
    end
  end

  // driver tasks (all called just after a falling edge)
  task automatic apply_reset();
    reset_n = 1'b0;
    wq.delete();
    init_cyc = 32'h3fff_ffff;
    for (int i = 0; i < NUM_CH; i++) begin m_div[i] = 0; m_n[i] = 0; end
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    wr_log.delete();
    wq.push_back('{cyc + 1, 3'd2, PERIOD[15:0]});
    wq.push_back('{cyc + 2, 3'd3, PERIOD[31:16]});
    wq.push_back('{cyc + 3, 3'd1, 16'h0001});
    init_cyc = cyc + 4;
  endtask

  task automatic cfg(input int ch, input int div);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_div = DIV_W'(div);
    if (ch < NUM_CH) begin m_div[ch] = div; m_n[ch] = 0; end
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // One timeout as seen by the channels: returns the expected tick mask.
  function automatic logic [NUM_CH-1:0] model_update(input bit coinc, input int cch, input int cdiv);
    logic [NUM_CH-1:0] mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (coinc && cch == i) begin
        m_div[i] = cdiv; m_n[i] = 0;
      end else if (m_div[i] != 0) begin
        m_n[i]++;
        if (m_n[i] % m_div[i] == 0) mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

  // irq is high from cycle k+1, so the status write is expected at k+2
  // and the ticks at k+3.
  task automatic do_timeout(input bit coinc, input int cch, input int cdiv);
    int k;
    logic [NUM_CH-1:0] mask;
    k = cyc;
    fire_req = 1'b1;
    wq.push_back('{k + 2, 3'd0, 16'h0000});
    mask = model_update(coinc, cch, cdiv);
    if (mask != '0) exp_tick[k + 3] = mask;
    @(negedge clk); fire_req = 1'b0;
    @(negedge clk);
    if (coinc) begin cfg_wr = 1'b1; cfg_ch = 3'(cch); cfg_div = DIV_W'(cdiv); end
    @(negedge clk); cfg_wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_snap(input bit with_irq, input logic [31:0] cnt_val);
    int k;
    logic [NUM_CH-1:0] mask;
    k = cyc;
    tmr_counter = cnt_val;
    snap_req = 1'b1;
    if (with_irq) begin
      fire_req = 1'b1;
      wq.push_back('{k + 2, 3'd0, 16'h0000});
      mask = model_update(1'b0, 0, 0);
      if (mask != '0) exp_tick[k + 3] = mask;
    end
`ifdef TICK_SCHED_SNAPSHOT_EN
    if (with_irq) begin
      wq.push_back('{k + 5, 3'd4, 16'h0000});
      exp_snap[k + 9] = cnt_val;
    end else begin
      wq.push_back('{k + 2, 3'd4, 16'h0000});
      exp_snap[k + 6] = cnt_val;
    end
`endif
    @(negedge clk); snap_req = 1'b0; fire_req = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_init_log();
    check("init_wr_count", wr_log.size(), 32'd3);
    if (wr_log.size() >= 3) begin
      check("init_wr_per_l", 32'(wr_log[0]), 32'h0002_C34F);
      check("init_wr_per_h", 32'(wr_log[1]), 32'h0003_0000);
      check("init_wr_ctrl",  32'(wr_log[2]), 32'h0001_0001);
    end
    check("init_done_lit", 32'(init_done), 32'h1);
  endtask

  task automatic clear_tick_cnt();
    for (int i = 0; i < NUM_CH; i++) tick_cnt[i] = 0;
  endtask

  // main sequence
  initial begin
    cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_div = '0; snap_req = 1'b0;
    fire_req = 1'b0; tmr_counter = 32'h0;
    clear_tick_cnt();
    apply_reset();
    repeat (3) @(negedge clk);
    check("reset_tick_lit", 32'(tick_out), 32'h0);
    release_reset();
    @(negedge clk);
    cfg(0, 1);                        // load during init
    repeat (4) @(negedge clk);
    check_init_log();

    // ch0 div=1, ch1 div=3; out-of-range indices must be dropped
    cfg(1, 3);
    cfg(7, 1);
    cfg(5, 2);
    clear_tick_cnt();
    repeat (6) do_timeout(1'b0, 0, 0);
    check("six_to_ch0", tick_cnt[0], 32'd6);
    check("six_to_ch1", tick_cnt[1], 32'd2);
    check("six_to_ch2", tick_cnt[2], 32'd0);

    // reload ch1 on the edge where it would have ticked
    clear_tick_cnt();
    repeat (2) do_timeout(1'b0, 0, 0);
    do_timeout(1'b1, 1, 3);
    repeat (3) do_timeout(1'b0, 0, 0);
    check("coinc_ch0", tick_cnt[0], 32'd6);
    check("coinc_ch1", tick_cnt[1], 32'd1);

    // disable ch0, divide-by-2 on ch3, very large ratio on ch2
    cfg(0, 0);
    cfg(3, 2);
    cfg(2, 16'hFFFF);
    clear_tick_cnt();
    repeat (4) do_timeout(1'b0, 0, 0);
    check("dis_ch0", tick_cnt[0], 32'd0);
    check("div2_ch3", tick_cnt[3], 32'd2);
    check("big_ch2", tick_cnt[2], 32'd0);

    // snapshots: coincident with irq, then alone
    do_snap(1'b1, 32'h0000_1234);
    do_snap(1'b0, 32'hABCD_5678);

    // reset while the per_h write is on the bus
    apply_reset();
    repeat (2) @(negedge clk);
    release_reset();
    repeat (2) @(negedge clk);
    apply_reset();
    repeat (2) @(negedge clk);
    release_reset();
    repeat (5) @(negedge clk);
    check_init_log();
    cfg(0, 1);
    clear_tick_cnt();
    repeat (2) do_timeout(1'b0, 0, 0);
    check("post_reset_ch0", tick_cnt[0], 32'd2);
    check("post_reset_ch1", tick_cnt[1], 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
